wos_select: RTL
===============

# wos_select

Weighted order-statistic selector: the read side of the rank tracker. When a window update completes, it latches the sample window, the per-position ranks and the per-position weights. It then walks the ranks from smallest to largest, accumulating weights until the running sum reaches a programmable threshold, and emits the sample at that point as the filter output. It sits directly downstream of the rank tracker in the rank-order filter datapath and drives the filter result register.

## Interface
- data_bits, 8: width of one sample
- rank_bits, 2: width of one rank; requires N ≤ 2^rank_bits
- N, 3: window length
- weight_bits, 4: width of one position weight
- acc_bits, weight_bits+rank_bits: accumulator and threshold width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock; the single clock
- rst  in  1  reset; asynchronous and active-low
- i_start  in  1  one-cycle pulse: window and ranks are valid this cycle
- s  in  data_bits*N  window samples; position p at [p*data_bits +: data_bits]
- ranks  in  rank_bits*N  rank of position p at [p*rank_bits +: rank_bits]; 0 is the smallest sample
- weights  in  weight_bits*N  weight of position p
- threshold  in  acc_bits  cumulative-weight target
- o_busy  out  1  scan in progress
- o_valid  out  1  one-cycle result strobe
- o_data  out  data_bits  selected sample; held until the next result
- o_rank  out  rank_bits  rank of the selected sample
- o_sat  out  1  total weight was below threshold; the maximum sample was output
- o_err  out  1  some rank in 0..N-1 had no matching position during the scan

## Operation
- States:
  - IDLE → SCAN on i_start.
  - SCAN → IDLE on hit, saturation or error completion.
- i_start in IDLE:
  - Latch s, ranks, weights and threshold into shadow registers.
  - Clear acc, the rank counter r, o_sat and o_err.
- i_start while in SCAN is ignored. The shadow registers are not disturbed.
- Each SCAN cycle:
  - Find the position p whose shadow rank equals r. If several match, the lowest p wins.
  - Compute sum = acc + weight[p], at acc_bits wide with no overflow possible.
  - If sum ≥ threshold: o_data = s[p], o_rank = r, pulse o_valid, go to IDLE.
  - Else, if r == N-1: output the rank N-1 sample, set o_sat = 1, pulse o_valid, go to IDLE.
  - Else: acc = sum, r = r+1.
- No position matches rank r:
  - Set o_err = 1 and add 0 to acc.
  - Continue scanning.
  - If the scan ends at r = N-1 with no match, o_data = 0.
- threshold = 0 always hits at r = 0, i.e. outputs the minimum sample.
- Weights of 0 are legal. A zero-weight sample is selected only if it is the first sample to reach the threshold.
- o_data, o_rank, o_sat and o_err hold their values until the next o_valid. o_sat and o_err are cleared on the next i_start.

## Timing
- Reset (async assert, sync release): state IDLE; o_busy, o_valid, o_data, o_rank, o_sat, o_err, acc and r all 0.
- i_start is sampled at edge E0. o_busy is high from E0.
- The evaluation of rank k happens between E(k) and E(k+1).
- If the hit occurs at rank k:
  - o_valid is high for exactly one cycle, after edge E(k+1). Latency is k+1 cycles, minimum 1, maximum N.
  - o_busy drops at the same edge E(k+1).
- Back-to-back operation: i_start in the cycle where o_valid is high is accepted. Throughput is one result per k+1 cycles.
- Reset asserted mid-scan:
  - Immediate return to IDLE with all outputs 0.
  - No o_valid is generated for the aborted scan.
- i_start coincident with reset deassertion is not required to be captured.

## Test plan
Common setup: N=3, data_bits=8, s = {p0=30, p1=10, p2=20}, ranks = {p0=2, p1=0, p2=1}.

- Median case. Weights 1,1,1, threshold 2 → o_valid 2 cycles after E0, o_data=20, o_rank=1, o_sat=0, o_err=0.
- Minimum case. Threshold 0 → o_valid 1 cycle after E0, o_data=10, o_rank=0.
- Saturation.
  - Weights 1,1,1, threshold 5 → o_valid after 3 cycles, o_data=30, o_rank=2, o_sat=1.
  - A following start with threshold 1 → o_sat=0, o_data=10.
- Weighted and back-to-back.
  - Weights {p0=3, p1=0, p2=1}, threshold 2 → acc 0, then 1, then 4 → o_data=30, o_rank=2, o_sat=0, latency 3.
  - A second i_start in the o_valid cycle with threshold 1 → o_data=20 after 2 cycles.
- Error and busy.
  - Ranks all 0, weights 1,1,1, threshold 3 → o_err=1, o_sat=1, o_data=0 after 3 cycles.
  - An i_start pulsed mid-scan is ignored (no extra o_valid).
- Reset mid-scan. Assert rst during cycle 2 of a threshold-5 scan → all outputs 0 immediately, no o_valid; the next start completes normally.

Source files
------------

// File: rtl/wos_select.sv
// rtl/wos_select.sv - weighted order-statistic selector
//
// Latches a sample window with its ranks and weights on i_start.
// It then walks the ranks upward from 0, summing weights until the sum reaches
// the threshold. The sample at that rank becomes the filter output.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   i_start    one-cycle start pulse (accepted only while idle)
//   s          window samples, position p at [p*data_bits +: data_bits]
//   ranks      rank of position p at [p*rank_bits +: rank_bits], 0 = smallest
//   weights    weight of position p at [p*weight_bits +: weight_bits]
//   threshold  cumulative-weight target
//   o_busy     scan in progress
//   o_valid    one-cycle result strobe
//   o_data     selected sample, held until the next result
//   o_rank     rank of the selected sample
//   o_sat      total weight never reached threshold; top-rank sample output
//   o_err      some rank had no matching position during the scan
module wos_select #(
   parameter int data_bits   = 8,
   parameter int rank_bits   = 2,
   parameter int N           = 3,
   parameter int weight_bits = 4,
   localparam int acc_bits   = weight_bits + rank_bits
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic [data_bits*N-1:0]     s,
   input  logic [rank_bits*N-1:0]     ranks,
   input  logic [weight_bits*N-1:0]   weights,
   input  logic [acc_bits-1:0]        threshold,
   output logic                       o_busy,
   output logic                       o_valid,
   output logic [data_bits-1:0]       o_data,
   output logic [rank_bits-1:0]       o_rank,
   output logic                       o_sat,
   output logic                       o_err
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t state, state_nxt;

   logic [data_bits-1:0]   sh_s    [N];
   logic [rank_bits-1:0]   sh_rank [N];
   logic [weight_bits-1:0] sh_w    [N];
   logic [acc_bits-1:0]    sh_thr;
   logic [acc_bits-1:0]    acc;
   logic [rank_bits-1:0]   r;

   logic                   found;
   logic [data_bits-1:0]   sel_data;
   logic [weight_bits-1:0] sel_w;
   logic [acc_bits-1:0]    sum;
   logic                   hit;
   logic                   last;
   logic                   done;

   // Descending walk so the lowest matching position is the one left standing.
   // With no match, sel_w stays 0 (adds nothing) and sel_data stays 0.
   always_comb begin
      found    = 1'b0;
      sel_data = '0;
      sel_w    = '0;
      for (int p = N - 1; p >= 0; p--) begin
         if (sh_rank[p] == r) begin
            found    = 1'b1;
            sel_data = sh_s[p];
            sel_w    = sh_w[p];
         end
      end
      // acc_bits covers N * max weight since N <= 2^rank_bits.
      sum  = acc + acc_bits'(sel_w);
      hit  = (sum >= sh_thr);
      last = (r == rank_bits'(N - 1));
      done = (state == SCAN) && (hit || last);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = SCAN;
         SCAN:    if (done)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < N; p++) begin
            sh_s[p]    <= '0;
            sh_rank[p] <= '0;
            sh_w[p]    <= '0;
         end
         sh_thr  <= '0;
         acc     <= '0;
         r       <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_rank  <= '0;
         o_sat   <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (state == IDLE && i_start) begin
            for (int p = 0; p < N; p++) begin
               sh_s[p]    <= s[p*data_bits +: data_bits];
               sh_rank[p] <= ranks[p*rank_bits +: rank_bits];
               sh_w[p]    <= weights[p*weight_bits +: weight_bits];
            end
            sh_thr <= threshold;
            acc    <= '0;
            r      <= '0;
            o_sat  <= 1'b0;
            o_err  <= 1'b0;
         end else if (state == SCAN) begin
            if (!found) o_err <= 1'b1;
            if (done) begin
               o_valid <= 1'b1;
               o_data  <= sel_data;
               o_rank  <= r;
               o_sat   <= ~hit;
            end else begin
               acc <= sum;
               r   <= r + 1'b1;
            end
         end
      end
   end

   assign o_busy = (state == SCAN);

endmodule
